// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
// Byte-stream command engine giving a host debug access to the asm18 system
// over a UART byte link: block memory reads/writes on CHANNELS ports,
// processor reset, wait/continue release and debug-register readback.
//
// Command byte = {opcode[3:0], channel[3:0]}; multi-byte fields little-endian.
//   0x1 WRITE addr,count,words -> A5   0x2 READ addr,count -> words
//   0x3 RESET arg -> A5                0x4 CONTINUE -> A5 / EE
//   0x5 DEBUG arg -> word              0x6 STATUS -> {6'b0,prst,wfc}
//
// Ports
//   clock, reset (async, active-high)
//   rx_data/rx_valid            received byte strobe, no backpressure
//   tx_data/tx_valid/tx_ready   transmit byte handshake
//   mem_address/mem_write/mem_wren/mem_read   shared memory port-b bus
//   processor_reset, wait_for_continue, wait_continue_execution
//   debug_get_param, debug_reg_addr, debug_data_out
//   status_led {last opcode, error, busy, processor_reset, wait_for_continue}
//
// Optional feature: define RX_TIMEOUT_EN to enable the inter-byte timeout
// (TIMEOUT_CLKS clocks without a byte while collecting a command -> NAK).
module uart_mem_bridge #(
   parameter int WORD_SIZE    = 18,
   parameter int ADDR_SIZE    = 18,
   parameter int CHANNELS     = 2,
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT_CLKS = 2000000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [ADDR_SIZE-1:0]          mem_address,
   output logic [WORD_SIZE-1:0]          mem_write,
   output logic [CHANNELS-1:0]           mem_wren,
   input  logic [CHANNELS*WORD_SIZE-1:0] mem_read,
   output logic                          processor_reset,
   input  logic                          wait_for_continue,
   output logic                          wait_continue_execution,
   output logic                          debug_get_param,
   output logic [3:0]                    debug_reg_addr,
   input  logic [WORD_SIZE-1:0]          debug_data_out,
   output logic [7:0]                    status_led
);

   localparam int WORD_BYTES = (WORD_SIZE + 7) / 8;
   localparam int ADDR_BYTES = (ADDR_SIZE + 7) / 8;

   localparam logic [3:0] OP_WRITE  = 4'h1;
   localparam logic [3:0] OP_READ   = 4'h2;
   localparam logic [3:0] OP_RESET  = 4'h3;
   localparam logic [3:0] OP_CONT   = 4'h4;
   localparam logic [3:0] OP_DEBUG  = 4'h5;
   localparam logic [3:0] OP_STATUS = 4'h6;
   localparam logic [7:0] ACK       = 8'hA5;
   localparam logic [7:0] NAK       = 8'hEE;

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_COUNT, GET_ARG, WR_DATA, WR_STROBE,
      RD_ISSUE, RD_WAIT, RD_SEND, DBG_WAIT, RESP
   } state_t;

   // Byte i (little-endian) of a word; bits above WORD_SIZE come out as 0.
   function automatic logic [7:0] byte_of(input logic [WORD_SIZE-1:0] w, input logic [3:0] i);
      byte_of = 8'(w >> {i, 3'b000});
   endfunction

   state_t                 state_q, state_d;
   logic [3:0]             op_q, op_d, ch_q, ch_d, idx_q, idx_d, daddr_q, daddr_d;
   logic [8:0]             cnt_q, cnt_d;
   logic [1:0]             lat_q, lat_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [WORD_SIZE-1:0]   word_q, word_d, rd_word_s;
   logic [CHANNELS-1:0]    wren_q, wren_d, chan_sel_s;
   logic [7:0]             txd_q, txd_d, led_q, led_d;
   logic                   txv_q, txv_d, prst_q, prst_d, wcont_q, wcont_d;
   logic                   dget_q, dget_d, err_q, err_d;

`ifdef RX_TIMEOUT_EN
   logic [31:0]            tmo_q, tmo_d;
`else
   logic                   unused_tmo_s;
   assign unused_tmo_s = (TIMEOUT_CLKS > 0);
`endif

   // Channel decode: selected read word and one-hot write-enable pattern.
   always_comb begin
      rd_word_s  = '0;
      chan_sel_s = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         chan_sel_s[k] = (ch_q == 4'(k));
         rd_word_s     = (ch_q == 4'(k)) ? mem_read[k*WORD_SIZE +: WORD_SIZE] : rd_word_s;
      end
   end

   // Command FSM: next state and all next register values.
   always_comb begin
      state_d = state_q;  op_d = op_q;      ch_d = ch_q;      idx_d = idx_q;
      cnt_d   = cnt_q;    lat_d = lat_q;    addr_d = addr_q;  word_d = word_q;
      txd_d   = txd_q;    txv_d = txv_q;    prst_d = prst_q;  dget_d = dget_q;
      daddr_d = daddr_q;  err_d = err_q;
      wren_d  = '0;
      wcont_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               op_d  = rx_data[7:4];
               ch_d  = rx_data[3:0];
               idx_d = 4'd0;
               err_d = 1'b0;
               case (rx_data[7:4])
                  OP_WRITE, OP_READ: begin
                     if (int'(rx_data[3:0]) < CHANNELS) begin
                        addr_d  = '0;
                        state_d = GET_ADDR;
                     end else begin
                        err_d = 1'b1;  txd_d = NAK;  txv_d = 1'b1;  state_d = RESP;
                     end
                  end
                  OP_RESET, OP_DEBUG: state_d = GET_ARG;
                  OP_CONT: begin
                     wcont_d = wait_for_continue;
                     txd_d   = wait_for_continue ? ACK : NAK;
                     txv_d   = 1'b1;
                     state_d = RESP;
                  end
                  OP_STATUS: begin
                     txd_d = {6'b000000, prst_q, wait_for_continue};  txv_d = 1'b1;  state_d = RESP;
                  end
                  default: begin
                     err_d = 1'b1;  txd_d = NAK;  txv_d = 1'b1;  state_d = RESP;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         GET_ADDR: begin
            if (rx_valid) begin
               // Shifting past ADDR_SIZE discards the unused high address bits.
               addr_d = addr_q | (ADDR_SIZE'(rx_data) << {idx_q, 3'b000});
               if (idx_q == 4'(ADDR_BYTES - 1)) begin
                  idx_d = 4'd0;  state_d = GET_COUNT;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               state_d = GET_ADDR;
            end
         end
         GET_COUNT: begin
            if (rx_valid) begin
               cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
               idx_d   = 4'd0;
               state_d = (op_q == OP_WRITE) ? WR_DATA : RD_ISSUE;
            end else begin
               state_d = GET_COUNT;
            end
         end
         GET_ARG: begin
            if (!rx_valid) begin
               state_d = GET_ARG;
            end else if (op_q == OP_RESET) begin
               prst_d = rx_data[0];  txd_d = ACK;  txv_d = 1'b1;  state_d = RESP;
            end else begin
               daddr_d = rx_data[3:0];  dget_d = 1'b1;  lat_d = 2'd0;  state_d = DBG_WAIT;
            end
         end
         WR_DATA: begin
            if (rx_valid) begin
               word_d = ((idx_q == 4'd0) ? '0 : word_q) | (WORD_SIZE'(rx_data) << {idx_q, 3'b000});
               if (idx_q == 4'(WORD_BYTES - 1)) begin
                  wren_d  = chan_sel_s;
                  state_d = WR_STROBE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               state_d = WR_DATA;
            end
         end
         WR_STROBE: begin
            // mem_wren is high this clock; advance to the next word.
            addr_d = addr_q + ADDR_SIZE'(1);
            cnt_d  = cnt_q - 9'd1;
            idx_d  = 4'd0;
            if (cnt_q == 9'd1) begin
               txd_d = ACK;  txv_d = 1'b1;  state_d = RESP;
            end else if (rx_valid) begin
               // A byte arriving on the strobe clock starts the next word.
               word_d = WORD_SIZE'(rx_data);
               if (WORD_BYTES == 1) begin
                  wren_d = chan_sel_s;  state_d = WR_STROBE;
               end else begin
                  idx_d = 4'd1;  state_d = WR_DATA;
               end
            end else begin
               state_d = WR_DATA;
            end
         end
         RD_ISSUE: begin
            lat_d   = 2'd1;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (lat_q == 2'(READ_LATENCY)) begin
               word_d = rd_word_s;  idx_d = 4'd0;
               txd_d  = byte_of(rd_word_s, 4'd0);  txv_d = 1'b1;  state_d = RD_SEND;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         RD_SEND: begin
            if (!tx_ready) begin
               state_d = RD_SEND;
            end else if (idx_q == 4'(WORD_BYTES - 1)) begin
               txv_d = 1'b0;
               cnt_d = cnt_q - 9'd1;
               addr_d  = (op_q == OP_READ) ? addr_q + ADDR_SIZE'(1) : addr_q;
               state_d = (cnt_q == 9'd1) ? IDLE : RD_ISSUE;
            end else begin
               idx_d = idx_q + 4'd1;
               txd_d = byte_of(word_q, idx_q + 4'd1);
            end
         end
         DBG_WAIT: begin
            // debug_get_param stays high two clocks; sample on the second.
            if (lat_q == 2'd0) begin
               lat_d = 2'd1;
            end else begin
               dget_d = 1'b0;  word_d = debug_data_out;  cnt_d = 9'd1;  idx_d = 4'd0;
               txd_d  = byte_of(debug_data_out, 4'd0);  txv_d = 1'b1;  state_d = RD_SEND;
            end
         end
         RESP: begin
            if (tx_ready) begin
               txv_d = 1'b0;  state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef RX_TIMEOUT_EN
      tmo_d = 32'd0;
      if ((state_q inside {GET_ADDR, GET_COUNT, GET_ARG, WR_DATA}) && !rx_valid) begin
         if (tmo_q == 32'(TIMEOUT_CLKS - 1)) begin
            wren_d = '0;  err_d = 1'b1;  dget_d = 1'b0;
            txd_d  = NAK;  txv_d = 1'b1;  state_d = RESP;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end else begin
         tmo_d = 32'd0;
      end
`endif

      led_d = {op_d, err_d, (state_d != IDLE), prst_d, wait_for_continue};
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;   op_q  <= 4'd0;   ch_q   <= 4'd0;  idx_q   <= 4'd0;
         cnt_q   <= 9'd0;   lat_q <= 2'd0;   addr_q <= '0;    word_q  <= '0;
         wren_q  <= '0;     txd_q <= 8'h00;  txv_q  <= 1'b0;  prst_q  <= 1'b1;
         wcont_q <= 1'b0;   dget_q <= 1'b0;  daddr_q <= 4'd0; err_q   <= 1'b0;
         led_q   <= 8'h02;
`ifdef RX_TIMEOUT_EN
         tmo_q   <= 32'd0;
`endif
      end else begin
         state_q <= state_d;  op_q  <= op_d;   ch_q   <= ch_d;    idx_q   <= idx_d;
         cnt_q   <= cnt_d;    lat_q <= lat_d;  addr_q <= addr_d;  word_q  <= word_d;
         wren_q  <= wren_d;   txd_q <= txd_d;  txv_q  <= txv_d;   prst_q  <= prst_d;
         wcont_q <= wcont_d;  dget_q <= dget_d; daddr_q <= daddr_d; err_q <= err_d;
         led_q   <= led_d;
`ifdef RX_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign tx_data                 = txd_q;
   assign tx_valid                = txv_q;
   assign mem_address             = addr_q;
   assign mem_write               = word_q;
   assign mem_wren                = wren_q;
   assign processor_reset         = prst_q;
   assign wait_continue_execution = wcont_q;
   assign debug_get_param         = dget_q;
   assign debug_reg_addr          = daddr_q;
   assign status_led              = led_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed testbench for uart_mem_bridge (WORD_SIZE=18, ADDR_SIZE=18, CHANNELS=2).
// A small synchronous memory (READ_LATENCY=1) sits on the port-b bus; tx bytes,
// write strobes, continue pulses and debug-select cycles are logged on the
// falling edge and compared against hand-computed expectations.
module tb_uart_mem_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [17:0] mem_address;
   logic [17:0] mem_write;
   logic [1:0]  mem_wren;
   logic [35:0] mem_read;
   logic        processor_reset;
   logic        wait_for_continue;
   logic        wait_continue_execution;
   logic        debug_get_param;
   logic [3:0]  debug_reg_addr;
   logic [17:0] debug_data_out;
   logic [7:0]  status_led;

   always #5 clock = ~clock;

   uart_mem_bridge #(
      .WORD_SIZE(18), .ADDR_SIZE(18), .CHANNELS(2), .READ_LATENCY(1), .TIMEOUT_CLKS(100)
   ) dut (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mem_address(mem_address), .mem_write(mem_write), .mem_wren(mem_wren),
      .mem_read(mem_read), .processor_reset(processor_reset),
      .wait_for_continue(wait_for_continue),
      .wait_continue_execution(wait_continue_execution),
      .debug_get_param(debug_get_param), .debug_reg_addr(debug_reg_addr),
      .debug_data_out(debug_data_out), .status_led(status_led)
   );

   // Two 256-word channel memories, one-clock read latency.
   logic [17:0] mem0 [256];
   logic [17:0] mem1 [256];
   logic [17:0] rd0, rd1;
   assign mem_read = {rd1, rd0};

   always @(posedge clock) begin
      if (mem_wren[0]) mem0[mem_address[7:0]] <= mem_write;
      if (mem_wren[1]) mem1[mem_address[7:0]] <= mem_write;
      rd0 <= mem0[mem_address[7:0]];
      rd1 <= mem1[mem_address[7:0]];
   end

   logic [7:0]  txq [$];
   logic [37:0] wrq [$];
   int          wcont_cnt = 0;
   int          gp_total  = 0;
   int          gp_run    = 0;
   int          phase     = 0;
   logic        ready_toggle = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          tx_base = 0;
   int          wr_base = 0;

   // Falling-edge driver for tx_ready/debug data and logger of DUT events.
   initial begin
      tx_ready       = 1'b1;
      debug_data_out = 18'h00000;
      forever begin
         @(negedge clock);
         phase    = (phase + 1) % 3;
         tx_ready = ready_toggle ? (phase == 0) : 1'b1;
         if (tx_valid && tx_ready) txq.push_back(tx_data);
         if (mem_wren != 2'b00) wrq.push_back({mem_wren, mem_address, mem_write});
         if (wait_continue_execution) wcont_cnt++;
         if (debug_get_param) begin
            gp_run++;
            gp_total++;
         end else begin
            gp_run = 0;
         end
         debug_data_out = (gp_run == 2) ? 18'h12345 : 18'h3C3C3;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic mark();
      tx_base = txq.size();
      wr_base = wrq.size();
   endtask

   // Wait (bounded) for n response bytes, then settle so extra bytes show up.
   task automatic wait_tx(input string tag, input int n);
      int k;
      k = 0;
      while ((txq.size() - tx_base) < n && k < 3000) begin
         @(negedge clock);
         k++;
      end
      repeat (20) @(negedge clock);
      chk({tag, "_count"}, 64'(txq.size() - tx_base), 64'(n));
   endtask

   // exp holds the expected bytes little-endian: first byte in exp[7:0].
   task automatic chk_bytes(input string tag, input int n, input logic [47:0] exp);
      for (int i = 0; i < n; i++) begin
         if (tx_base + i < txq.size())
            chk(tag, 64'(txq[tx_base + i]), 64'(exp[i*8 +: 8]));
         else
            chk(tag, 64'hDEAD, 64'(exp[i*8 +: 8]));
      end
   endtask

   int wc0;

   initial begin
      reset             = 1'b1;
      rx_valid          = 1'b0;
      rx_data           = 8'h00;
      wait_for_continue = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_tx_valid",  64'(tx_valid), 64'd0);
      chk("rst_tx_data",   64'(tx_data), 64'd0);
      chk("rst_wren",      64'(mem_wren), 64'd0);
      chk("rst_addr",      64'(mem_address), 64'd0);
      chk("rst_wdata",     64'(mem_write), 64'd0);
      chk("rst_prst",      64'(processor_reset), 64'd1);
      chk("rst_wcont",     64'(wait_continue_execution), 64'd0);
      chk("rst_dget",      64'(debug_get_param), 64'd0);
      chk("rst_daddr",     64'(debug_reg_addr), 64'd0);
      chk("rst_led",       64'(status_led), 64'h02);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Two-word write to channel 0 at 0x10.
      mark();
      send(8'h10); send(8'h10); send(8'h00); send(8'h00); send(8'h02);
      send(8'hFF); send(8'hFF); send(8'h03); send(8'h01); send(8'h00); send(8'h00);
      wait_tx("wr_ack", 1);
      chk_bytes("wr_ack", 1, 48'hA5);
      chk("wr_count", 64'(wrq.size() - wr_base), 64'd2);
      chk("wr_word0", 64'(wrq[wr_base]),     64'({2'b01, 18'h00010, 18'h3FFFF}));
      chk("wr_word1", 64'(wrq[wr_base + 1]), 64'({2'b01, 18'h00011, 18'h00001}));

      // Read back, tx_ready always high.
      mark();
      send(8'h20); send(8'h10); send(8'h00); send(8'h00); send(8'h02);
      wait_tx("rd", 6);
      chk_bytes("rd", 6, 48'h0000_0103_FFFF);

      // Same read with tx_ready high one clock in three.
      ready_toggle = 1'b1;
      mark();
      send(8'h20); send(8'h10); send(8'h00); send(8'h00); send(8'h02);
      wait_tx("rd_slow", 6);
      chk_bytes("rd_slow", 6, 48'h0000_0103_FFFF);
      ready_toggle = 1'b0;

      // Channel 1: high data bits are discarded on write and read back as 0.
      mark();
      send(8'h11); send(8'h20); send(8'h00); send(8'h00); send(8'h01);
      send(8'hCD); send(8'hAB); send(8'hFE);
      wait_tx("wr1_ack", 1);
      chk_bytes("wr1_ack", 1, 48'hA5);
      chk("wr1_word", 64'(wrq[wr_base]), 64'({2'b10, 18'h00020, 18'h2ABCD}));
      mark();
      send(8'h21); send(8'h20); send(8'h00); send(8'h00); send(8'h01);
      wait_tx("rd1", 3);
      chk_bytes("rd1", 3, 48'h02ABCD);

      // Bad channel, bad opcode, then status.
      mark();
      send(8'h12);
      wait_tx("badch", 1);
      chk_bytes("badch", 1, 48'hEE);
      chk("badch_nowren", 64'(wrq.size() - wr_base), 64'd0);
      mark();
      send(8'hF0);
      wait_tx("badop", 1);
      chk_bytes("badop", 1, 48'hEE);
      chk("badop_led", 64'(status_led), 64'hFA);
      mark();
      send(8'h60);
      wait_tx("status", 1);
      chk_bytes("status", 1, 48'h02);
      chk("status_led", 64'(status_led), 64'h62);

      // Continue while not waiting, then while waiting.
      wc0 = wcont_cnt;
      mark();
      send(8'h40);
      wait_tx("cont_nak", 1);
      chk_bytes("cont_nak", 1, 48'hEE);
      chk("cont_nopulse", 64'(wcont_cnt - wc0), 64'd0);
      wait_for_continue = 1'b1;
      wc0 = wcont_cnt;
      mark();
      send(8'h40);
      wait_tx("cont_ack", 1);
      chk_bytes("cont_ack", 1, 48'hA5);
      chk("cont_pulse", 64'(wcont_cnt - wc0), 64'd1);
      mark();
      send(8'h60);
      wait_tx("status_wfc", 1);
      chk_bytes("status_wfc", 1, 48'h03);
      mark();
      send(8'h30); send(8'h00);
      wait_tx("prst_ack", 1);
      chk_bytes("prst_ack", 1, 48'hA5);
      chk("prst_low", 64'(processor_reset), 64'd0);
      chk("prst_led", 64'(status_led), 64'h31);
      wait_for_continue = 1'b0;

      // Debug register 7; value presented only on the 2nd select clock.
      wc0 = gp_total;
      mark();
      send(8'h55); send(8'h07);
      wait_tx("dbg", 3);
      chk_bytes("dbg", 3, 48'h012345);
      chk("dbg_addr", 64'(debug_reg_addr), 64'h7);
      chk("dbg_sel_clocks", 64'(gp_total - wc0), 64'd2);

      // Address wrap on write (high address bits ignored) and on read.
      mark();
      send(8'h10); send(8'hFF); send(8'hFF); send(8'hFF); send(8'h02);
      send(8'h11); send(8'h11); send(8'h00); send(8'h22); send(8'h22); send(8'h01);
      wait_tx("wrap_wr", 1);
      chk_bytes("wrap_wr", 1, 48'hA5);
      chk("wrap_wr0", 64'(wrq[wr_base]),     64'({2'b01, 18'h3FFFF, 18'h01111}));
      chk("wrap_wr1", 64'(wrq[wr_base + 1]), 64'({2'b01, 18'h00000, 18'h12222}));
      mark();
      send(8'h20); send(8'hFF); send(8'hFF); send(8'h03); send(8'h02);
      wait_tx("wrap_rd", 6);
      chk_bytes("wrap_rd", 6, 48'h0122_2200_1111);

      // Reset in the middle of a data word: no write, reset values return.
      mark();
      send(8'h10); send(8'h30); send(8'h00); send(8'h00); send(8'h01);
      send(8'hAA); send(8'hBB);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_addr", 64'(mem_address), 64'd0);
      chk("mid_rst_prst", 64'(processor_reset), 64'd1);
      chk("mid_rst_led",  64'(status_led), 64'h02);
      chk("mid_rst_txv",  64'(tx_valid), 64'd0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      chk("mid_rst_nowren", 64'(wrq.size() - wr_base), 64'd0);
      send(8'h60);
      wait_tx("post_rst_status", 1);
      chk_bytes("post_rst_status", 1, 48'h02);

`ifdef RX_TIMEOUT_EN
      // Inter-byte timeout of 100 clocks while collecting the address.
      mark();
      send(8'h10); send(8'h10);
      repeat (85) @(negedge clock);
      chk("tmo_not_early", 64'(txq.size() - tx_base), 64'd0);
      wait_tx("tmo_nak", 1);
      chk_bytes("tmo_nak", 1, 48'hEE);
      chk("tmo_err_led", 64'(status_led[3]), 64'd1);
      chk("tmo_nowren", 64'(wrq.size() - wr_base), 64'd0);
      mark();
      send(8'h60);
      wait_tx("tmo_status", 1);
      chk_bytes("tmo_status", 1, 48'h02);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
Byte-stream command engine that gives a host debug access to the asm18 system over a UART byte link. It performs memory reads and writes on CHANNELS independent memory ports, with parametrised word and address widths, and supports block transfers with address auto-increment. It also drives processor reset, the wait/continue handshake and debug-register readback. It sits between the UART rx/tx byte layer and the port-b side of the code/data memories.

Parameters:
WORD_SIZE, 18, memory word width; WORD_BYTES=(WORD_SIZE+7)/8 bytes on the wire.
ADDR_SIZE, 18, memory address width; ADDR_BYTES=(ADDR_SIZE+7)/8 bytes on the wire.
CHANNELS, 2, number of memory ports (1..16); channel 0=code, 1=data.
READ_LATENCY, 1, clocks from mem_address valid to mem_read valid (1..3).
TIMEOUT_CLKS, 2000000, inter-byte timeout (used only with RX_TIMEOUT_EN).

Ports:
clock  in  1  single clock.
reset  in  1  asynchronous, active-high.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe; no backpressure.
tx_data  out  8  byte to transmit.
tx_valid  out  1  tx byte valid; held until accepted.
tx_ready  in  1  transmitter accepts when tx_valid&tx_ready.
mem_address  out  ADDR_SIZE  shared address, all channels.
mem_write  out  WORD_SIZE  shared write data.
mem_wren  out  CHANNELS  one-hot write enable.
mem_read  in  CHANNELS*WORD_SIZE  read data; channel k at [k*WORD_SIZE +: WORD_SIZE].
processor_reset  out  1  holds processor in reset.
wait_for_continue  in  1  processor halted, waiting.
wait_continue_execution  out  1  one-cycle release pulse.
debug_get_param  out  1  high while a debug register is selected.
debug_reg_addr  out  4  debug register index.
debug_data_out  in  WORD_SIZE  debug register value.
status_led  out  8  {last opcode[3:0], error, busy, processor_reset, wait_for_continue}.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, mem_wren=0, mem_address=0, mem_write=0, processor_reset=1, wait_continue_execution=0, debug_get_param=0, debug_reg_addr=0, status_led=8'h02 (processor_reset bit set). State returns to IDLE. Reset mid-command aborts immediately; no partial write is completed.
- Command byte: [7:4]=opcode, [3:0]=channel. Multi-byte fields are little-endian. Address bits above ADDR_SIZE are ignored; word bits above WORD_SIZE read back as 0 and are ignored on write.
- Opcodes:
  - 0x1 WRITE: addr, count (0 means 256), count words. Response ACK 0xA5 after the last write.
  - 0x2 READ: addr, count. Response is count words.
  - 0x3 RESET: 1 arg byte; bit0 sets processor_reset. Response ACK.
  - 0x4 CONTINUE: if wait_for_continue=1, pulse wait_continue_execution for exactly 1 clock and respond ACK; otherwise respond NAK 0xEE.
  - 0x5 DEBUG: 1 arg byte; low 4 bits go to debug_reg_addr. debug_get_param is held high for 2 clocks, debug_data_out is sampled on the 2nd clock, and the word is returned.
  - 0x6 STATUS: respond {6'b0, processor_reset, wait_for_continue}.
  - Channel field is ignored for 0x3–0x6.
- Errors: an unknown opcode, or channel>=CHANNELS on 0x1/0x2, gives an immediate NAK and a return to IDLE, with the error LED bit set until the next valid command.
- States: IDLE, GET_ADDR, GET_COUNT, GET_ARG, WR_DATA, WR_STROBE, RD_ISSUE, RD_WAIT, RD_SEND, DBG_WAIT, RESP.
- Write timing: after the WORD_BYTES-th byte of a word, mem_wren[ch]=1 for exactly 1 clock, with mem_address and mem_write stable that clock. The address then increments.
- Read timing: drive mem_address, wait READ_LATENCY clocks, capture word, then send WORD_BYTES bytes under tx handshake. The next address is issued only after the last byte is accepted.
- Addresses wrap modulo 2^ADDR_SIZE.
- tx: tx_data is stable while tx_valid=1 and tx_ready=0. There is no combinational path from tx_ready to tx_valid.
- rx_valid while in RD_*, DBG_WAIT or RESP: byte is dropped; the host must await the response.
- busy LED bit is 1 whenever state!=IDLE.

Optional Feature:
RX_TIMEOUT_EN:
- Defined: an inter-byte counter runs in GET_ADDR, GET_COUNT, GET_ARG and WR_DATA. It reloads on each rx_valid. If TIMEOUT_CLKS pass with no byte, the engine returns to IDLE with no pending write, sends NAK 0xEE, and sets the error LED bit.
- Undefined: no counter; the engine waits indefinitely for bytes.

Test Plan:
1. Write, WORD_SIZE=18, CHANNELS=2: rx 10 10 00 00 02 FF FF 03 01 00 00 -> mem_wren=01 for 1 clock at addr 0x10 data 0x3FFFF, then at 0x11 data 0x00001; tx A5.
2. Read back: rx 20 10 00 00 02 with memory preloaded -> tx FF FF 03 01 00 00. Repeat with tx_ready toggled 1-in-3 -> same bytes, no loss.
3. Bad channel and opcode: rx 12 -> tx EE, no wren. rx F0 -> tx EE. Following rx 60 -> tx 02 (power-up processor_reset=1, wait_for_continue=0).
4. Continue: wait_for_continue=0, rx 40 -> tx EE, no pulse. Set 1, rx 40 -> wait_continue_execution high exactly 1 clock, tx A5. Also rx 30 00 -> processor_reset=0, tx A5.
5. Wrap: read at addr 0x3FFFF count 2 -> mem_address 0x3FFFF then 0x00000. Assert reset mid-WR_DATA -> no wren, outputs at reset values.
6. RX_TIMEOUT_EN with TIMEOUT_CLKS=100: rx 10 10 then silence -> tx EE after 100 clocks. Next rx 60 is parsed normally.
